// File: rtl/game_fsm_pkg.sv
// game_fsm_pkg: shared state codes, winner codes and parameter defaults for the tank game controller
package game_fsm_pkg;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_RESPAWN   = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_LOCAL = 2'd1;
    localparam logic [1:0] WIN_OP    = 2'd2;
    localparam logic [1:0] WIN_DRAW  = 2'd3;

    localparam int DEF_LIVES           = 3;
    localparam int DEF_COUNT_FRAMES    = 60;
    localparam int DEF_RESPAWN_FRAMES  = 90;
    localparam int DEF_COOLDOWN_FRAMES = 30;
    localparam int DEF_GAMEOVER_FRAMES = 180;
endpackage

// File: rtl/game_fsm_edge_detect.sv
// edge_detect: one-cycle pulse on a rising edge of a clk-domain level
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;
    // previous level, so a 0->1 change shows up for exactly one cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) d_q <= 1'b0;
        else d_q <= d;
    assign rise = d & ~d_q;
endmodule

// File: rtl/game_fsm.sv
// game_fsm: game flow controller (countdown, play, respawn, game over) with lives, fire cooldown and link supervision
module game_fsm
    import game_fsm_pkg::*;
#(
    parameter int LIVES           = DEF_LIVES,
    parameter int COUNT_FRAMES    = DEF_COUNT_FRAMES,
    parameter int RESPAWN_FRAMES  = DEF_RESPAWN_FRAMES,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_start,
    input  logic       btn_fire,
    input  logic       link_ok,
    input  logic       hit_local,
    input  logic       hit_op,
    output logic       select_mode,
    output logic [2:0] game_state,
    output logic [1:0] countdown,
    output logic [1:0] lives_local,
    output logic [1:0] lives_op,
    output logic       fire,
    output logic [1:0] winner
);
    localparam logic [1:0] LIVES_LD = 2'(LIVES);
    localparam logic [7:0] CNT_LD   = 8'(COUNT_FRAMES - 1);
    localparam logic [7:0] RSP_LD   = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0] CD_LD    = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] GO_LD    = 8'(GAMEOVER_FRAMES - 1);

    logic       tick, start_ev, fire_ev, hit, expire;
    logic [2:0] state;
    logic [7:0] frame_cnt, cooldown;
    logic [1:0] nl_local, nl_op;

    edge_detect u_vsync (.clk(clk), .rst(rst), .d(vsync),     .rise(tick));
    edge_detect u_start (.clk(clk), .rst(rst), .d(btn_start), .rise(start_ev));
    edge_detect u_fire  (.clk(clk), .rst(rst), .d(btn_fire),  .rise(fire_ev));

    assign game_state = state;

    // saturating post-hit lives and frame-counter expiry
    always_comb begin
        hit      = hit_local | hit_op;
        nl_local = (hit_local && lives_local != 2'd0) ? lives_local - 2'd1 : lives_local;
        nl_op    = (hit_op && lives_op != 2'd0) ? lives_op - 2'd1 : lives_op;
        expire   = tick && frame_cnt == 8'd0;
    end

    // game state machine; link loss overrides everything, then hits, then fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            select_mode <= 1'b0;
            countdown   <= 2'd0;
            lives_local <= LIVES_LD;
            lives_op    <= LIVES_LD;
            fire        <= 1'b0;
            winner      <= WIN_NONE;
            cooldown    <= 8'd0;
            frame_cnt   <= 8'd0;
        end else begin
            fire <= 1'b0;
            if (state != ST_IDLE && !link_ok) begin
                state       <= ST_IDLE;
                select_mode <= 1'b0;
                countdown   <= 2'd0;
                lives_local <= LIVES_LD;
                lives_op    <= LIVES_LD;
                winner      <= WIN_NONE;
                cooldown    <= 8'd0;
                frame_cnt   <= 8'd0;
            end else begin
                case (state)
                    ST_IDLE: if (start_ev && link_ok) begin
                        state       <= ST_COUNTDOWN;
                        lives_local <= LIVES_LD;
                        lives_op    <= LIVES_LD;
                        winner      <= WIN_NONE;
                        countdown   <= 2'd3;
                        frame_cnt   <= CNT_LD;
                    end
                    ST_COUNTDOWN: if (expire) begin
                        if (countdown == 2'd1) begin
                            state       <= ST_PLAY;
                            select_mode <= 1'b1;
                            countdown   <= 2'd0;
                            cooldown    <= 8'd0;
                            frame_cnt   <= 8'd0;
                        end else begin
                            countdown <= countdown - 2'd1;
                            frame_cnt <= CNT_LD;
                        end
                    end else if (tick) frame_cnt <= frame_cnt - 8'd1;
                    ST_PLAY: begin
                        if (tick && cooldown != 8'd0) cooldown <= cooldown - 8'd1;
                        if (hit) begin
                            lives_local <= nl_local;
                            lives_op    <= nl_op;
                            select_mode <= 1'b0;
                            if (nl_local == 2'd0 || nl_op == 2'd0) begin
                                state     <= ST_GAME_OVER;
                                winner    <= {nl_local == 2'd0, nl_op == 2'd0};
                                frame_cnt <= GO_LD;
                            end else begin
                                state     <= ST_RESPAWN;
                                frame_cnt <= RSP_LD;
                            end
                        end else if (fire_ev && cooldown == 8'd0) begin
                            fire     <= 1'b1;
                            cooldown <= CD_LD;
                        end
                    end
                    ST_RESPAWN: if (expire) begin
                        state       <= ST_PLAY;
                        select_mode <= 1'b1;
                        cooldown    <= 8'd0;
                        frame_cnt   <= 8'd0;
                    end else if (tick) frame_cnt <= frame_cnt - 8'd1;
                    ST_GAME_OVER: if (start_ev || expire) begin
                        state     <= ST_IDLE;
                        frame_cnt <= 8'd0;
                    end else if (tick) frame_cnt <= frame_cnt - 8'd1;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: scoreboard bench for game_fsm; instance a has 3 lives, instance b has 1 life
module tb_game_fsm;
    localparam logic [2:0] S_IDLE = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_RSP = 3'd3, S_GO = 3'd4;

    typedef struct packed {
        logic       inst;
        logic [2:0] st;
        logic       sel;
        logic [1:0] cd;
        logic [1:0] ll;
        logic [1:0] lo;
        logic [1:0] win;
    } snap_t;

    logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, btn_start = 1'b0, btn_fire = 1'b0;
    logic link_ok = 1'b1, hit_local = 1'b0, hit_op = 1'b0;
    logic       sel_a, fire_a, sel_b, fire_b;
    logic [2:0] gs_a, gs_b;
    logic [1:0] cd_a, ll_a, lo_a, win_a, cd_b, ll_b, lo_b, win_b;

    snap_t snap_q[$];
    string name_q[$];
    string fire_q[$];
    snap_t e_s, g_s;
    string nm_s, nm_f;
    int    n_cmp = 0, n_bad = 0;
    logic [1:0] cd_seq [6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};

    game_fsm #(.LIVES(3), .COUNT_FRAMES(2), .RESPAWN_FRAMES(2), .COOLDOWN_FRAMES(2), .GAMEOVER_FRAMES(3)) u_a (
        .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start), .btn_fire(btn_fire),
        .link_ok(link_ok), .hit_local(hit_local), .hit_op(hit_op), .select_mode(sel_a),
        .game_state(gs_a), .countdown(cd_a), .lives_local(ll_a), .lives_op(lo_a),
        .fire(fire_a), .winner(win_a)
    );

    game_fsm #(.LIVES(1), .COUNT_FRAMES(2), .RESPAWN_FRAMES(2), .COOLDOWN_FRAMES(2), .GAMEOVER_FRAMES(3)) u_b (
        .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start), .btn_fire(btn_fire),
        .link_ok(link_ok), .hit_local(hit_local), .hit_op(hit_op), .select_mode(sel_b),
        .game_state(gs_b), .countdown(cd_b), .lives_local(ll_b), .lives_op(lo_b),
        .fire(fire_b), .winner(win_b)
    );

    always #5 clk = ~clk;

    // monitor: on each falling edge drain pending snapshots and match fire pulses against expected shots
    always @(negedge clk) begin
        while (snap_q.size() > 0) begin
            e_s  = snap_q.pop_front();
            nm_s = name_q.pop_front();
            g_s  = e_s.inst ? {1'b1, gs_b, sel_b, cd_b, ll_b, lo_b, win_b}
                            : {1'b0, gs_a, sel_a, cd_a, ll_a, lo_a, win_a};
            n_cmp++;
            if (g_s !== e_s) begin
                n_bad++;
                $display("FAIL %s: got st=%0d sel=%0d cd=%0d ll=%0d lo=%0d win=%0d, want st=%0d sel=%0d cd=%0d ll=%0d lo=%0d win=%0d",
                         nm_s, g_s.st, g_s.sel, g_s.cd, g_s.ll, g_s.lo, g_s.win,
                         e_s.st, e_s.sel, e_s.cd, e_s.ll, e_s.lo, e_s.win);
            end
        end
        if (fire_a !== 1'b0) begin
            n_cmp++;
            if (fire_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_fire: got fire=%b at %0t, want fire=0", fire_a, $time);
            end else nm_f = fire_q.pop_front();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        step();
    endtask

    task automatic expect_s(input string nm, input logic inst, input logic [2:0] st, input logic sel,
                            input logic [1:0] cd, input logic [1:0] ll, input logic [1:0] lo, input logic [1:0] win);
        snap_q.push_back({inst, st, sel, cd, ll, lo, win});
        name_q.push_back(nm);
    endtask

    task automatic fire_edge();
        btn_fire = 1'b1;
        step();
        btn_fire = 1'b0;
        step();
    endtask

    task automatic chk_fire(input string nm);
        n_cmp++;
        if (fire_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d shots still pending, want 0", nm, fire_q.size());
        end
    endtask

    task automatic start_game();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_s($sformatf("countdown_%0d", i), 1'b0, S_CD, 1'b0, cd_seq[i], 2'd3, 2'd3, 2'd0);
            frame();
        end
        expect_s("play_entry", 1'b0, S_PLAY, 1'b1, 2'd0, 2'd3, 2'd3, 2'd0);
    endtask

    task automatic pulse_hit(input logic l, input logic o);
        hit_local = l;
        hit_op    = o;
        step();
        hit_local = 1'b0;
        hit_op    = 1'b0;
    endtask

    // directed stimulus; expectations go to the scoreboard queues
    initial begin
        step();
        step();
        expect_s("reset_a", 1'b0, S_IDLE, 1'b0, 2'd0, 2'd3, 2'd3, 2'd0);
        expect_s("reset_b", 1'b1, S_IDLE, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0);
        step();
        rst = 1'b0;
        step();

        start_game();
        fire_q.push_back("fire_1");
        fire_edge();
        chk_fire("fire_1_seen");
        frame();
        fire_edge();
        frame();
        fire_q.push_back("fire_3");
        fire_edge();
        chk_fire("fire_3_seen");
        frame();
        frame();

        btn_fire = 1'b1;
        pulse_hit(1'b0, 1'b1);
        btn_fire = 1'b0;
        expect_s("hit1_respawn", 1'b0, S_RSP, 1'b0, 2'd0, 2'd3, 2'd2, 2'd0);
        fire_edge();
        pulse_hit(1'b1, 1'b0);
        frame();
        frame();
        expect_s("respawn1_done", 1'b0, S_PLAY, 1'b1, 2'd0, 2'd3, 2'd2, 2'd0);
        pulse_hit(1'b0, 1'b1);
        expect_s("hit2_respawn", 1'b0, S_RSP, 1'b0, 2'd0, 2'd3, 2'd1, 2'd0);
        frame();
        frame();
        expect_s("respawn2_done", 1'b0, S_PLAY, 1'b1, 2'd0, 2'd3, 2'd1, 2'd0);
        pulse_hit(1'b0, 1'b1);
        expect_s("hit3_game_over", 1'b0, S_GO, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1);
        frame();
        frame();
        expect_s("game_over_hold", 1'b0, S_GO, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1);
        frame();
        expect_s("game_over_timeout", 1'b0, S_IDLE, 1'b0, 2'd0, 2'd3, 2'd0, 2'd1);

        start_game();
        pulse_hit(1'b1, 1'b0);
        expect_s("local_hit_respawn", 1'b0, S_RSP, 1'b0, 2'd0, 2'd2, 2'd3, 2'd0);
        link_ok = 1'b0;
        step();
        expect_s("link_loss", 1'b0, S_IDLE, 1'b0, 2'd0, 2'd3, 2'd3, 2'd0);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        expect_s("start_without_link", 1'b0, S_IDLE, 1'b0, 2'd0, 2'd3, 2'd3, 2'd0);
        link_ok = 1'b1;
        step();

        start_game();
        btn_fire = 1'b1;
        step();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        btn_fire = 1'b0;
        expect_s("async_reset_a", 1'b0, S_IDLE, 1'b0, 2'd0, 2'd3, 2'd3, 2'd0);
        expect_s("async_reset_b", 1'b1, S_IDLE, 1'b0, 2'd0, 2'd1, 2'd1, 2'd0);
        step();
        step();

        start_game();
        expect_s("b_play", 1'b1, S_PLAY, 1'b1, 2'd0, 2'd1, 2'd1, 2'd0);
        pulse_hit(1'b1, 1'b1);
        expect_s("double_hit_a", 1'b0, S_RSP, 1'b0, 2'd0, 2'd2, 2'd2, 2'd0);
        expect_s("draw_b", 1'b1, S_GO, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
        step();
        expect_s("draw_no_respawn_b", 1'b1, S_GO, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        expect_s("start_exits_game_over_b", 1'b1, S_IDLE, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3);
        expect_s("start_ignored_respawn_a", 1'b0, S_RSP, 1'b0, 2'd0, 2'd2, 2'd2, 2'd0);

        for (int i = 0; i < 10 && snap_q.size() > 0; i++) step();
        step();
        n_cmp++;
        if (snap_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d snapshots pending, want 0", snap_q.size());
        end
        chk_fire("final_shots");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
